// File: rtl/ibex_fetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues word fetches, buffers responses in a FIFO, flushes on branch.
// Optional macro IBEX_PREFETCH_ERR_HALT_EN stops new fetches after a bus error until the next branch.

module ibex_fetch_prefetch_buffer_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full,
  input logic rvalid,
  input logic idle
);

  // Credit accounting must make an overflowing push and an unsolicited response impossible.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop)) else $error("prefetch fifo overflow");
      assert (!(rvalid && idle)) else $error("response with no outstanding request");
    end
  end

endmodule

module ibex_fetch_prefetch_buffer #(
  parameter int NumReqs   = 2,
  parameter int FifoDepth = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int CntW  = $clog2(NumReqs + 1);
  localparam int FCntW = $clog2(FifoDepth + 1);
  localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int SumW  = $clog2(FifoDepth + NumReqs + 1);

  logic [31:0]      fetch_addr_q;
  logic [31:0]      pend_addr_q;
  logic [31:0]      resp_addr_q;
  logic             pend_q;
  logic             pend_stale_q;
  logic [CntW-1:0]  outstanding_q;
  logic [CntW-1:0]  outstanding_d;
  logic [CntW-1:0]  discard_q;
  logic [CntW-1:0]  discard_d;
  logic [31:0]      fifo_rdata [FifoDepth];
  logic [31:0]      fifo_addr [FifoDepth];
  logic [FifoDepth-1:0] fifo_err;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [FCntW-1:0] fifo_cnt_q;
  logic [FCntW-1:0] fifo_cnt_d;
  logic             valid_q;
  logic [SumW-1:0]  credit_used;
  logic [31:0]      branch_addr;
  logic             issue;
  logic             gnt;
  logic             push;
  logic             pop;
  logic             halt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(FifoDepth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  assign branch_addr = {addr_i[31:2], 2'b00};

  // Credits cover words already buffered plus live (non-discarded) responses still to arrive.
  assign credit_used = SumW'(fifo_cnt_q) + SumW'(outstanding_q - discard_q);

  assign issue = !rst_i && !pend_q && req_i && !branch_i && !halt &&
                 (outstanding_q < CntW'(NumReqs)) && (credit_used < SumW'(FifoDepth));

  assign instr_req_o  = pend_q | issue;
  assign instr_addr_o = pend_q ? pend_addr_q : fetch_addr_q;
  assign gnt          = instr_req_o & instr_gnt_i;
  assign push         = instr_rvalid_i & (discard_q == {CntW{1'b0}}) & ~branch_i;
  assign pop          = valid_q & ready_i & ~branch_i;

  assign outstanding_d = outstanding_q + CntW'(gnt) - CntW'(instr_rvalid_i);
  assign fifo_cnt_d    = fifo_cnt_q + FCntW'(push) - FCntW'(pop);

  // A request granted after the branch that overtook it belongs to the old stream.
  always_comb begin
    discard_d = discard_q;
    if (branch_i) begin
      discard_d = outstanding_d;
    end else begin
      discard_d = discard_q
                - CntW'(instr_rvalid_i && (discard_q != {CntW{1'b0}}))
                + CntW'(gnt && pend_stale_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_addr_q  <= 32'h0;
      pend_addr_q   <= 32'h0;
      pend_q        <= 1'b0;
      pend_stale_q  <= 1'b0;
      outstanding_q <= {CntW{1'b0}};
      discard_q     <= {CntW{1'b0}};
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (branch_i) begin
        fetch_addr_q <= branch_addr;
      end else if (gnt && !pend_stale_q) begin
        fetch_addr_q <= fetch_addr_q + 32'd4;
      end
      if (instr_req_o && !instr_gnt_i) begin
        pend_q       <= 1'b1;
        pend_addr_q  <= instr_addr_o;
        pend_stale_q <= pend_stale_q | branch_i;
      end else begin
        pend_q       <= 1'b0;
        pend_stale_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q    <= {PtrW{1'b0}};
      wr_ptr_q    <= {PtrW{1'b0}};
      fifo_cnt_q  <= {FCntW{1'b0}};
      valid_q     <= 1'b0;
      resp_addr_q <= 32'h0;
      fifo_err    <= {FifoDepth{1'b0}};
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_rdata[i] <= 32'h0;
        fifo_addr[i]  <= 32'h0;
      end
    end else if (branch_i) begin
      rd_ptr_q    <= {PtrW{1'b0}};
      wr_ptr_q    <= {PtrW{1'b0}};
      fifo_cnt_q  <= {FCntW{1'b0}};
      valid_q     <= 1'b0;
      resp_addr_q <= branch_addr;
    end else begin
      if (push) begin
        fifo_rdata[wr_ptr_q] <= instr_rdata_i;
        fifo_addr[wr_ptr_q]  <= resp_addr_q;
        fifo_err[wr_ptr_q]   <= instr_err_i;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
        resp_addr_q          <= resp_addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_cnt_q <= fifo_cnt_d;
      valid_q    <= (fifo_cnt_d != {FCntW{1'b0}});
    end
  end

`ifdef IBEX_PREFETCH_ERR_HALT_EN
  logic err_halt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_halt_q <= 1'b0;
    end else if (branch_i) begin
      err_halt_q <= 1'b0;
    end else if (push && instr_err_i) begin
      err_halt_q <= 1'b1;
    end
  end

  assign halt = err_halt_q;
`else
  assign halt = 1'b0;
`endif

  assign valid_o = valid_q;
  assign rdata_o = fifo_rdata[rd_ptr_q];
  assign addr_o  = fifo_addr[rd_ptr_q];
  assign err_o   = fifo_err[rd_ptr_q];
  assign busy_o  = instr_req_o | (outstanding_q != {CntW{1'b0}});

  ibex_fetch_prefetch_buffer_chk u_chk (
    .clk    (clk_i),
    .rst    (rst_i),
    .push   (push),
    .pop    (pop),
    .full   (fifo_cnt_q == FCntW'(FifoDepth)),
    .rvalid (instr_rvalid_i),
    .idle   (outstanding_q == {CntW{1'b0}})
  );

endmodule

// File: tb/tb_ibex_fetch_prefetch_buffer.sv
// Directed bench for the prefetch buffer: in-order bus model plus a queue of expected output words.
module tb_ibex_fetch_prefetch_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        busy_o;

  ibex_fetch_prefetch_buffer #(.NumReqs(2), .FifoDepth(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .err_o          (err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          gnt_cnt = 0;
  int          max_out = 0;
  int          rv_cyc = -1;
  int          vo_cyc = -1;
  logic        lat_arm = 1'b0;
  logic        gnt_en = 1'b1;
  logic        rsp_en = 1'b1;
  logic        watch_req = 1'b0;
  logic        seen_req = 1'b0;
  logic [31:0] seen_req_addr = 32'h0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] bus_q [$];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] bus_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_word();
    logic [31:0] e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL unexpected_word observed addr=%h expected no word", addr_o);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("word_addr", addr_o, e);
      chk("word_rdata", rdata_o, bus_word(e));
      chk("word_err", {31'h0, err_o}, {31'h0, (e == err_addr)});
    end
  endtask

  // One clock: bus responds in order one cycle after grant, grants combinationally when enabled.
  task automatic tick();
    logic [31:0] a;
    @(negedge clk_i);
    if (rsp_en && bus_q.size() > 0) begin
      a = bus_q.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = bus_word(a);
      instr_err_i    = (a == err_addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      instr_err_i    = 1'b0;
    end
    #1;
    instr_gnt_i = gnt_en & instr_req_o;
    #1;
    if (instr_req_o && instr_gnt_i) begin
      bus_q.push_back(instr_addr_o);
      gnt_cnt++;
    end
    if (bus_q.size() > max_out) max_out = bus_q.size();
    if (watch_req && instr_req_o && !seen_req) begin
      seen_req      = 1'b1;
      seen_req_addr = instr_addr_o;
    end
    if (lat_arm) begin
      if (instr_rvalid_i && rv_cyc < 0) rv_cyc = cyc;
      if (valid_o && vo_cyc < 0) vo_cyc = cyc;
    end
    if (valid_o && ready_i && !branch_i) check_word();
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_branch(input logic [31:0] target, input int n);
    logic [31:0] base;
    base = {target[31:2], 2'b00};
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i) * 32'd4);
    gnt_cnt  = 0;
    branch_i = 1'b1;
    addr_i   = target;
    tick();
    branch_i = 1'b0;
    addr_i   = 32'h0;
    chk("valid_after_branch", {31'h0, valid_o}, 32'h0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    chk("drain_remaining", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic quiesce();
    req_i   = 1'b0;
    ready_i = 1'b0;
    gnt_en  = 1'b1;
    rsp_en  = 1'b1;
    repeat (6) tick();
    chk("quiesce_busy", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = 32'h0; ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; instr_err_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_req", {31'h0, instr_req_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_instr_addr", instr_addr_o, 32'h0);

    // Linear fetch from 0x100 with a one-cycle response latency.
    quiesce();
    lat_arm = 1'b1; rv_cyc = -1; vo_cyc = -1;
    ready_i = 1'b1; req_i = 1'b1;
    do_branch(32'h100, 3);
    wait_drain(20);
    lat_arm = 1'b0;
    chk("first_valid_latency", 32'(vo_cyc - rv_cyc), 32'd1);

    // Backpressure: exactly FifoDepth words buffered, then requests resume at 0x10C.
    quiesce();
    req_i = 1'b1;
    do_branch(32'h100, 0);
    repeat (10) tick();
    chk("bp_grants", 32'(gnt_cnt), 32'd3);
    chk("bp_req_low", {31'h0, instr_req_o}, 32'h0);
    chk("bp_busy_low", {31'h0, busy_o}, 32'h0);
    chk("bp_valid", {31'h0, valid_o}, 32'h1);
    chk("bp_addr", addr_o, 32'h100);
    repeat (3) tick();
    chk("bp_addr_stable", addr_o, 32'h100);
    chk("bp_rdata_stable", rdata_o, bus_word(32'h100));
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h100 + 32'(i) * 32'd4);
    watch_req = 1'b1; seen_req = 1'b0;
    ready_i = 1'b1;
    wait_drain(30);
    watch_req = 1'b0;
    chk("bp_resume_seen", {31'h0, seen_req}, 32'h1);
    chk("bp_resume_addr", seen_req_addr, 32'h10C);

    // Branch with two outstanding responses: both must be dropped.
    quiesce();
    req_i = 1'b1; ready_i = 1'b1; rsp_en = 1'b0;
    do_branch(32'h100, 0);
    repeat (5) tick();
    chk("two_out_grants", 32'(gnt_cnt), 32'd2);
    chk("two_out_req_low", {31'h0, instr_req_o}, 32'h0);
    chk("two_out_busy", {31'h0, busy_o}, 32'h1);
    rsp_en = 1'b1;
    do_branch(32'h200, 3);
    wait_drain(20);

    // Branch while a request at 0x108 waits for a delayed grant.
    quiesce();
    req_i = 1'b1;
    do_branch(32'h100, 0);
    for (int i = 0; i < 10 && gnt_cnt < 2; i++) tick();
    chk("pend_setup_grants", 32'(gnt_cnt), 32'd2);
    gnt_en = 1'b0;
    tick();
    chk("pend_req", {31'h0, instr_req_o}, 32'h1);
    chk("pend_addr", instr_addr_o, 32'h108);
    ready_i = 1'b1;
    do_branch(32'h300, 2);
    for (int i = 0; i < 2; i++) begin
      chk("pend_hold_req", {31'h0, instr_req_o}, 32'h1);
      chk("pend_hold_addr", instr_addr_o, 32'h108);
      tick();
    end
    chk("pend_last_addr", instr_addr_o, 32'h108);
    gnt_en = 1'b1;
    tick();
    watch_req = 1'b1; seen_req = 1'b0;
    wait_drain(20);
    watch_req = 1'b0;
    chk("pend_next_req", seen_req_addr, 32'h300);

    // Error response on 0x104.
    quiesce();
    err_addr = 32'h104;
    req_i = 1'b1; ready_i = 1'b1;
`ifdef IBEX_PREFETCH_ERR_HALT_EN
    do_branch(32'h100, 3);
    wait_drain(30);
    repeat (4) tick();
    chk("halt_req_low", {31'h0, instr_req_o}, 32'h0);
    chk("halt_busy_low", {31'h0, busy_o}, 32'h0);
    chk("halt_valid_low", {31'h0, valid_o}, 32'h0);
`else
    do_branch(32'h100, 5);
    wait_drain(30);
    chk("err_continue_req", {31'h0, instr_req_o}, 32'h1);
`endif
    err_addr = 32'hFFFF_FFFF;

    // Address wrap through 0xFFFFFFFC, with an unaligned branch target.
    quiesce();
    req_i = 1'b1; ready_i = 1'b1;
    do_branch(32'hFFFF_FFFB, 3);
    wait_drain(20);

    chk("max_outstanding", {31'h0, (max_out <= 2)}, 32'h1);
    quiesce();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_fetch_prefetch_buffer.md
Name: ibex_fetch_prefetch_buffer

Overview:
- Word-granular instruction prefetcher directly upstream of the IF stage; drives the instruction bus (req/gnt/rvalid) and buffers returned words in a small FIFO.
- Hands words to the IF stage over a valid/ready handshake.
- On a branch from IF it flushes all buffered data, discards responses to in-flight requests and restarts at the new address.

Parameters:
- NumReqs, 2, maximum outstanding (granted, no rvalid yet) bus requests; 1..4
- FifoDepth, 3, FIFO entries; must be >= NumReqs

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-high
- req_i  input  1  fetch enable from IF; 0 blocks new bus requests
- branch_i  input  1  redirect fetch to addr_i
- addr_i  input  32  branch target
- ready_i  input  1  IF accepts the output word
- valid_o  output  1  output word valid
- rdata_o  output  32  instruction word
- addr_o  output  32  word-aligned address of rdata_o
- err_o  output  1  bus error on this word
- instr_req_o  output  1  bus request
- instr_addr_o  output  32  bus address, bits [1:0]=0
- instr_gnt_i  input  1  bus grant
- instr_rvalid_i  input  1  bus response valid
- instr_rdata_i  input  32  bus response data
- instr_err_i  input  1  bus response error, qualified by rvalid
- busy_o  output  1  outstanding requests or pending request present

Behaviour:
- Reset values:
  - all outputs 0
  - fetch_addr_q=0, outstanding count=0, discard count=0, FIFO empty
- Fetch address:
  - branch_i loads fetch_addr_q={addr_i[31:2],2'b00}.
  - Each grant of a non-discarded stream advances it by 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x0).
- Request issue:
  - instr_req_o=1 when req_i=1, outstanding<NumReqs, and FIFO_count+outstanding_valid<FifoDepth (credit check).
  - Once raised, instr_req_o and instr_addr_o hold until instr_gnt_i, regardless of req_i, branch_i or credit changes.
- Branch while a request is pending ungranted:
  - The request completes at its old address.
  - On grant it is counted as a discard.
  - The new address issues on the following cycle at earliest.
- Outstanding counter: +1 on grant, -1 on rvalid; both in the same cycle leaves it unchanged.
- Discard counter:
  - On branch_i it is set to outstanding_next, which includes a grant in the same cycle.
  - Each rvalid while discard>0 decrements it and drops the data.
  - rvalid in the same cycle as branch_i is always dropped.
- FIFO:
  - Push on rvalid with discard==0 and !branch_i, storing {rdata, word addr, err}.
  - Word addr comes from an internal response-address register that starts at the branch target and advances by 4 per push.
  - Pop on valid_o&&ready_i.
  - Simultaneous push and pop while full is legal.
  - Push when full cannot occur because of the credit check; an assertion covers this.
- Output:
  - valid_o = FIFO non-empty, fully registered, no bypass.
  - Latency: rvalid in cycle N gives valid_o in cycle N+1.
  - rdata_o, addr_o and err_o hold stable while valid_o && !ready_i.
- Flush:
  - branch_i empties the FIFO in the same cycle; valid_o=0 next cycle.
  - ready_i in a branch cycle is ignored.
- Error: err_o=1 accompanies the faulting word; prefetching continues unless the optional feature is enabled.
- busy_o = instr_req_o || outstanding!=0.
- Reset mid-transaction: all state clears asynchronously. The bus fabric is also reset, so no late responses are expected.

Optional Feature:
- Macro: IBEX_PREFETCH_ERR_HALT_EN.
- Defined:
  - A non-discarded error response sets err_halt_q, which blocks new requests; a request already pending stays until granted.
  - The next branch_i clears err_halt_q.
  - Responses already in flight are still pushed.
- Undefined: no halt logic; errors only tag words.

Test Plan:
- Linear fetch, branch to 0x100, gnt and rvalid every cycle, ready_i=1 -> addr_o sequence 0x100, 0x104, 0x108; first valid_o one cycle after first rvalid; outstanding never exceeds 2.
- ready_i=0 with FifoDepth=3 -> exactly 3 words buffered, instr_req_o drops, outputs stable; ready_i=1 resumes requests at 0x10C.
- Branch to 0x200 with 2 outstanding after fetches from 0x100 -> the two responses are dropped; the first valid_o shows addr_o=0x200.
- Branch while instr_req_o=1 at 0x108 ungranted, gnt delayed 3 cycles -> instr_addr_o stays 0x108 until grant; its response is discarded; the next request is 0x300.
- Error response on word 0x104 -> err_o=1 on that word only. With IBEX_PREFETCH_ERR_HALT_EN, no new instr_req_o until branch_i; without it, fetch continues at 0x108+.
- Branch to 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
